// File: rtl/irq_coalesce_if.sv
// Status/config/interrupt bundle between the status register bank, the CPU and irq_coalesce.
// master = bank/CPU side that drives status and acknowledges; slave = the coalescer.
interface irq_coalesce_if #(
  parameter int BITS_W = 8,
  parameter int CNT_W  = 8,
  parameter int TMO_W  = 16
);
  logic [BITS_W-1:0] status;
  logic [BITS_W-1:0] mask;
  logic [CNT_W-1:0]  cfg_thresh;
  logic [TMO_W-1:0]  cfg_tmo;
  logic              irq_ack;
  logic              irq;
  logic [BITS_W-1:0] irq_src;
  logic [CNT_W-1:0]  evt_cnt;

  modport master (
    output status, mask, cfg_thresh, cfg_tmo, irq_ack,
    input  irq, irq_src, evt_cnt
  );

  modport slave (
    input  status, mask, cfg_thresh, cfg_tmo, irq_ack,
    output irq, irq_src, evt_cnt
  );
endinterface

// File: rtl/irq_coalesce.sv
// Interrupt coalescer: counts rising masked status bits and fires one irq on threshold or timeout.
// Define IRQ_COALESCE_PULSE_EN for a 1-cycle irq pulse instead of a level held until irq_ack.
module irq_coalesce #(
  parameter int BITS_W = 8,
  parameter int CNT_W  = 8,
  parameter int TMO_W  = 16
) (
  input logic          clk,
  input logic          rst,
  irq_coalesce_if.slave bus
);
  localparam int PC_W = $clog2(BITS_W + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FIRE} state_e;

  state_e            state_q, state_d;
  logic              irq_q, irq_d;
  logic [BITS_W-1:0] irq_src_q, irq_src_d;
  logic [BITS_W-1:0] masked_prev_q;
  logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
  logic [TMO_W-1:0]  timer_q, timer_d;

  logic [BITS_W-1:0] masked, new_evt;
  logic [PC_W-1:0]   new_pop;
  logic [CNT_W:0]    cnt_sum;
  logic [CNT_W-1:0]  cnt_inc, thresh_eff;
  logic [TMO_W-1:0]  timer_inc;
  logic              fire, ack_eff;

  function automatic logic [PC_W-1:0] popcount(input logic [BITS_W-1:0] v);
    popcount = '0;
    for (int i = 0; i < BITS_W; i++) popcount = popcount + PC_W'(v[i]);
  endfunction

  assign masked  = bus.status & bus.mask;
  assign new_evt = masked & ~masked_prev_q;
  assign new_pop = popcount(new_evt);

  assign cnt_sum    = {1'b0, evt_cnt_q} + (CNT_W + 1)'(new_pop);
  assign cnt_inc    = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  assign timer_inc  = (timer_q == '1) ? timer_q : timer_q + TMO_W'(1);
  assign thresh_eff = (bus.cfg_thresh == '0) ? CNT_W'(1) : bus.cfg_thresh;
  assign fire       = (evt_cnt_q >= thresh_eff) ||
                      ((bus.cfg_tmo != '0) && (timer_q >= bus.cfg_tmo));

`ifdef IRQ_COALESCE_PULSE_EN
  // FIRE always lasts one cycle, so the acknowledge input plays no part.
  assign ack_eff = 1'b1;
  wire   unused_ack = bus.irq_ack;
`else
  assign ack_eff = bus.irq_ack;
`endif

  always_comb begin
    // NOTE: every _d gets its default first so no path through the case infers a latch.
    state_d   = state_q;
    irq_d     = irq_q;
    irq_src_d = irq_src_q;
    evt_cnt_d = evt_cnt_q;
    timer_d   = timer_q;

    if (state_q != FIRE) evt_cnt_d = cnt_inc;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (|masked) state_d = COLLECT;
      end
      COLLECT: begin
        if (masked == '0) begin
          state_d   = IDLE;
          evt_cnt_d = '0;
          timer_d   = '0;
        end else begin
          timer_d = timer_inc;
          if (fire) begin
            state_d   = FIRE;
            irq_d     = 1'b1;
            irq_src_d = masked;
          end
        end
      end
      FIRE: begin
        // Events arriving here are tracked in masked_prev_q but never counted.
        if (ack_eff) begin
          irq_d     = 1'b0;
          evt_cnt_d = '0;
          timer_d   = '0;
          state_d   = (|masked) ? COLLECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      irq_q         <= 1'b0;
      irq_src_q     <= '0;
      masked_prev_q <= '0;
      evt_cnt_q     <= '0;
      timer_q       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      state_q       <= state_d;
      irq_q         <= irq_d;
      irq_src_q     <= irq_src_d;
      masked_prev_q <= masked;
      evt_cnt_q     <= evt_cnt_d;
      timer_q       <= timer_d;
    end
  end

  assign bus.irq     = irq_q;
  assign bus.irq_src = irq_src_q;
  assign bus.evt_cnt = evt_cnt_q;
endmodule
